// File: rtl/cpu_hazard_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters that stall decode on RAW hazards.
// Optional feature: define SCOREBOARD_BYPASS_EN to let decode proceed when the last pending write retires this cycle.
module cpu_hazard_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        check_valid,
  input  logic [4:0]  check_rs,
  input  logic [4:0]  check_rt,
  output logic        reg_stall,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic [31:0] busy,
  output logic [7:0]  inflight_count,
  output logic        underflow_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [CNT_W-1:0] cnt      [32];
  logic [CNT_W-1:0] cnt_next [32];
  logic [31:0]      busy_next;
  logic [7:0]       inflight_next;

  logic issue_acc;
  logic wb_hit;
  logic wb_acc;
  logic wb_under;
  logic same_reg;
  logic pend_rs;
  logic pend_rt;

  // Register 0 is hardwired: it never pends and never saturates.
  function automatic logic pend(input logic [4:0] r);
    logic p;
    p = (r != 5'd0) && (cnt[r] != CNT_ZERO);
`ifdef SCOREBOARD_BYPASS_EN
    if (cnt[r] == CNT_ONE && wb_valid && wb_rd == r)
      p = 1'b0;
`endif
    return p;
  endfunction

  always_comb begin
    issue_ready = (issue_rd == 5'd0) || (cnt[issue_rd] != CNT_MAX);
    issue_acc   = issue_valid && issue_ready && (issue_rd != 5'd0);
    wb_hit      = wb_valid && (wb_rd != 5'd0);
    wb_acc      = wb_hit && (cnt[wb_rd] != CNT_ZERO);
    wb_under    = wb_hit && (cnt[wb_rd] == CNT_ZERO);
    same_reg    = issue_acc && wb_acc && (issue_rd == wb_rd);
    pend_rs     = pend(check_rs);
    pend_rt     = pend(check_rt);
    reg_stall   = check_valid && (pend_rs || pend_rt);
  end

  // An issue and a retire to the same register cancel, so neither counter nor total moves.
  always_comb begin
    for (int i = 0; i < 32; i++)
      cnt_next[i] = cnt[i];
    if (issue_acc && !same_reg)
      cnt_next[issue_rd] = cnt[issue_rd] + CNT_ONE;
    if (wb_acc && !same_reg)
      cnt_next[wb_rd] = cnt[wb_rd] - CNT_ONE;
    cnt_next[0] = CNT_ZERO;

    busy_next = '0;
    for (int i = 1; i < 32; i++)
      busy_next[i] = (cnt_next[i] != CNT_ZERO);

    inflight_next = inflight_count + {7'd0, issue_acc} - {7'd0, wb_acc};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        cnt[i] <= CNT_ZERO;
      busy           <= '0;
      inflight_count <= '0;
      underflow_err  <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++)
        cnt[i] <= CNT_ZERO;
      busy           <= '0;
      inflight_count <= '0;
    end else begin
      for (int i = 0; i < 32; i++)
        cnt[i] <= cnt_next[i];
      busy           <= busy_next;
      inflight_count <= inflight_next;
      if (wb_under)
        underflow_err <= 1'b1;
    end
  end

endmodule

// File: doc/cpu_hazard_scoreboard.md
# cpu_hazard_scoreboard

Register-hazard scoreboard for the in-order MIPS pipeline. It tracks how many in-flight instructions still have to write each general-purpose register. It drives `reg_stall` to the instruction-decode stage whenever a source operand (rs/rt) is still pending. Decode reports each instruction leaving it; writeback reports each register write retiring.

## Interface
Parameters:
- `CNT_W`, default 2: width of each per-register pending counter. Legal range is 1..3. The maximum number of in-flight writes per register is 2^CNT_W−1.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `flush`  in  1  synchronous pipeline flush; clears all counters and `inflight_count`. Sticky error flags are kept.
- `check_valid`  in  1  decode presents source registers this cycle.
- `check_rs`  in  5  source register s.
- `check_rt`  in  5  source register t.
- `reg_stall`  out  1  combinational; high means decode must hold and not read operands.
- `issue_valid`  in  1  an instruction with a destination leaves decode.
- `issue_rd`  in  5  destination register; 0 means untracked.
- `issue_ready`  out  1  combinational; low when `issue_rd`'s counter is saturated.
- `wb_valid`  in  1  writeback retires a register write.
- `wb_rd`  in  5  retired destination; 0 is ignored.
- `busy`  out  32  registered bitmap; bit i set when counter[i] ≠ 0. Bit 0 is always 0.
- `inflight_count`  out  8  registered sum of all counters.
- `underflow_err`  out  1  sticky; set when writeback targets a register whose counter is 0.

## Operation
State:
- `counter[1..31]`, each CNT_W bits.
- `inflight_count`.
- `underflow_err`.

Register 0 is never tracked. It never stalls and never counts.

Issue acceptance:
- An issue is accepted when `issue_valid && issue_ready && issue_rd≠0`.
- `issue_ready` = (issue_rd==0) || (counter[issue_rd] ≠ 2^CNT_W−1).
- A non-accepted issue has no effect. Decode must hold it.

Writeback acceptance:
- A writeback is accepted when `wb_valid && wb_rd≠0 && counter[wb_rd]≠0`.
- `wb_valid && wb_rd≠0 && counter[wb_rd]==0` sets `underflow_err`. The counter stays 0.

Counter update, per register r:
- +1 on an accepted issue to r.
- −1 on an accepted writeback from r.
- Both in the same cycle: unchanged.

`inflight_count` update:
- +1 on each accepted issue.
- −1 on each accepted writeback.
- Net 0 when both occur in the same cycle.

Stall equation:
- `reg_stall` = check_valid && (pend(check_rs) || pend(check_rt)).
- pend(x) = x≠0 && counter[x]≠0, subject to the bypass rule under Configuration.
- The check always uses the pre-edge counters. An issue in the same cycle does not affect it.

Update priority: reset > flush > issue/writeback.

`busy` is a registered image of the next-state counters, so it matches the counters after every edge.

## Timing
- Reset values:
  - `busy`=0, `inflight_count`=0, `underflow_err`=0.
  - `reg_stall`=0 and `issue_ready`=1 on the first cycle after reset, since all counters are 0.
- `reg_stall` and `issue_ready` are zero-latency combinational outputs from current state and inputs.
- Counter, `busy` and `inflight_count` changes are visible one cycle after the accepting edge.
- Reset or flush asserted mid-operation clears state at that edge; in-flight writebacks after a flush are counted as underflows.
- `check_rs` == `check_rt` is evaluated once; there is no double counting.

## Configuration
- `SCOREBOARD_BYPASS_EN` defined:
  - pend(x) is false when counter[x]==1 and `wb_valid && wb_rd==x` in the same cycle.
  - Decode proceeds, relying on the register file's write-through read.
- Undefined: any nonzero counter stalls, including one being retired this cycle. The stall clears the cycle after the writeback edge.

## Test plan
- Reset, then check rs=3, rt=4 with no issues → `reg_stall`=0, `busy`=0, `inflight_count`=0.
- Issue rd=5, next cycle check rs=5 → `reg_stall`=1, `busy`[5]=1. Writeback rd=5 → the following cycle `reg_stall`=0 and `busy`[5]=0.
- With CNT_W=2, issue rd=7 three times → `issue_ready`=0 for rd=7 and `inflight_count`=3. A fourth issue is ignored. One writeback → `issue_ready`=1.
- Issue rd=9 and writeback rd=9 in the same cycle with counter[9]=1 → counter stays 1 and `inflight_count` is unchanged. With bypass enabled, a check rs=9 that cycle → `reg_stall`=0; without bypass → 1.
- Writeback rd=12 with counter 0 → `underflow_err`=1, which stays set through flush and clears only on reset. Writeback rd=0 → no error.
- Issue rd=2, rd=3, then assert flush → next cycle `busy`=0 and `inflight_count`=0. Check rs=2 → `reg_stall`=0.
